// File: rtl/compute_gradients_if.sv
// Bundles the image-read port, the gradient-write port and the start/busy/done
// control of compute_gradients; master is the gradient engine, slave is memory/host.
interface compute_gradients_if #(
    parameter int DIMENSION     = 64,
    parameter int IMG_BIT_DEPTH = 8,
    parameter int BIT_DEPTH     = 9
);
    localparam int AW = $clog2(DIMENSION*DIMENSION);

    logic                     start;
    logic [AW-1:0]            img_read_addr;
    logic [IMG_BIT_DEPTH-1:0] img_pixel;
    logic [AW-1:0]            grad_write_addr;
    logic [BIT_DEPTH-1:0]     grad_x_out;
    logic [BIT_DEPTH-1:0]     grad_y_out;
    logic                     grad_wea;
    logic                     busy;
    logic                     gradients_done;

    modport master (
        input  start, img_pixel,
        output img_read_addr, grad_write_addr, grad_x_out, grad_y_out,
               grad_wea, busy, gradients_done
    );

    modport slave (
        output start, img_pixel,
        input  img_read_addr, grad_write_addr, grad_x_out, grad_y_out,
               grad_wea, busy, gradients_done
    );
endinterface

// File: rtl/compute_gradients.sv
// Central-difference Gx/Gy for every pixel of a BRAM image, written to the gradient BRAM pair.
// Latency: READ_LATENCY+5 cycles per pixel, done pulse at DIMENSION^2*P+1 after start.
// Backpressure: none; the engine free-runs once started and ignores start until back in IDLE.
module compute_gradients #(
    parameter int DIMENSION     = 64,
    parameter int IMG_BIT_DEPTH = 8,
    parameter int BIT_DEPTH     = 9,
    parameter int READ_LATENCY  = 2
) (
    input  logic                  clk,
    input  logic                  rst_in,
    compute_gradients_if.master   bus
);
    localparam int XW = $clog2(DIMENSION);
    localparam int AW = 2*XW;
    localparam int P  = READ_LATENCY + 5;
    localparam int PW = $clog2(P);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [PW-1:0] PH_CAP_L = PW'(READ_LATENCY);
    localparam logic [PW-1:0] PH_CAP_R = PW'(READ_LATENCY + 1);
    localparam logic [PW-1:0] PH_CAP_U = PW'(READ_LATENCY + 2);
    localparam logic [PW-1:0] PH_CALC  = PW'(P - 2);
    localparam logic [PW-1:0] PH_LAST  = PW'(P - 1);
    localparam logic [XW-1:0] XMAX     = XW'(DIMENSION - 1);

    logic [1:0]               state_q, state_d;
    logic [PW-1:0]            phase_q, phase_d;
    logic [XW-1:0]            x_q, x_d, y_q, y_d;
    logic [IMG_BIT_DEPTH-1:0] pl_q, pl_d, pr_q, pr_d, pu_q, pu_d;
    logic [AW-1:0]            img_read_addr_q, img_read_addr_d;
    logic [AW-1:0]            grad_write_addr_q, grad_write_addr_d;
    logic [BIT_DEPTH-1:0]     grad_x_q, grad_x_d, grad_y_q, grad_y_d;
    logic                     grad_wea_q, grad_wea_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;

    // Neighbour address for a read phase, clamped at the image border (replicate).
    function automatic logic [AW-1:0] rd_addr(input logic [PW-1:0] ph,
                                              input logic [XW-1:0] px,
                                              input logic [XW-1:0] py);
        logic [XW-1:0] ax;
        logic [XW-1:0] ay;
        ax = px;
        ay = py;
        if (ph == PW'(0))      ax = (px == '0)   ? px : px - XW'(1);
        else if (ph == PW'(1)) ax = (px == XMAX) ? px : px + XW'(1);
        else if (ph == PW'(2)) ay = (py == '0)   ? py : py - XW'(1);
        else if (ph == PW'(3)) ay = (py == XMAX) ? py : py + XW'(1);
        return {ay, ax};
    endfunction

    always_comb begin
        state_d           = state_q;
        phase_d           = phase_q;
        x_d               = x_q;
        y_d               = y_q;
        pl_d              = pl_q;
        pr_d              = pr_q;
        pu_d              = pu_q;
        img_read_addr_d   = img_read_addr_q;
        grad_write_addr_d = grad_write_addr_q;
        grad_x_d          = '0;
        grad_y_d          = '0;
        grad_wea_d        = 1'b0;
        busy_d            = busy_q;
        done_d            = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d         = S_RUN;
                    phase_d         = '0;
                    x_d             = '0;
                    y_d             = '0;
                    busy_d          = 1'b1;
                    img_read_addr_d = rd_addr('0, '0, '0);
                end
            end
            S_RUN: begin
                if (phase_q == PH_CAP_L) pl_d = bus.img_pixel;
                if (phase_q == PH_CAP_R) pr_d = bus.img_pixel;
                if (phase_q == PH_CAP_U) pu_d = bus.img_pixel;
                // D arrives on the same edge that registers the outputs, so it bypasses pD.
                if (phase_q == PH_CALC) begin
                    grad_wea_d        = 1'b1;
                    grad_write_addr_d = {y_q, x_q};
                    grad_x_d = BIT_DEPTH'({1'b0, pr_q}) - BIT_DEPTH'({1'b0, pl_q});
                    grad_y_d = BIT_DEPTH'({1'b0, bus.img_pixel}) - BIT_DEPTH'({1'b0, pu_q});
                end
                if (phase_q == PH_LAST) begin
                    phase_d = '0;
                    if (x_q == XMAX) begin
                        x_d = '0;
                        if (y_q == XMAX) begin
                            state_d = S_DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            y_d = y_q + XW'(1);
                        end
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                    if (state_d == S_RUN) img_read_addr_d = rd_addr('0, x_d, y_d);
                end else begin
                    phase_d = phase_q + PW'(1);
                    if (phase_q < PW'(3)) img_read_addr_d = rd_addr(phase_d, x_q, y_q);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            state_q           <= S_IDLE;
            phase_q           <= '0;
            x_q               <= '0;
            y_q               <= '0;
            pl_q              <= '0;
            pr_q              <= '0;
            pu_q              <= '0;
            img_read_addr_q   <= '0;
            grad_write_addr_q <= '0;
            grad_x_q          <= '0;
            grad_y_q          <= '0;
            grad_wea_q        <= 1'b0;
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
        end else begin
            state_q           <= state_d;
            phase_q           <= phase_d;
            x_q               <= x_d;
            y_q               <= y_d;
            pl_q              <= pl_d;
            pr_q              <= pr_d;
            pu_q              <= pu_d;
            img_read_addr_q   <= img_read_addr_d;
            grad_write_addr_q <= grad_write_addr_d;
            grad_x_q          <= grad_x_d;
            grad_y_q          <= grad_y_d;
            grad_wea_q        <= grad_wea_d;
            busy_q            <= busy_d;
            done_q            <= done_d;
        end
    end

    assign bus.img_read_addr   = img_read_addr_q;
    assign bus.grad_write_addr = grad_write_addr_q;
    assign bus.grad_x_out      = grad_x_q;
    assign bus.grad_y_out      = grad_y_q;
    assign bus.grad_wea        = grad_wea_q;
    assign bus.busy            = busy_q;
    assign bus.gradients_done  = done_q;
endmodule
